// File: rtl/sn7411_tri_and3.sv
// 7411 triple 3-input AND, pin-numbered for board netlists.
// Define SN7411_REG_OUT_EN to register the outputs on clk; default is combinational.
module sn7411_tri_and3 (
    input  logic P1,
    input  logic P2,
    input  logic P3,
    input  logic P4,
    input  logic P5,
    output logic P6,
    input  logic P7,
    output logic P8,
    input  logic P9,
    input  logic P10,
    input  logic P11,
    output logic P12,
    input  logic P13,
    input  logic P14,
    input  logic clk,
    input  logic rst
);

    logic supply_ok;
    logic gate_a;
    logic gate_b;
    logic gate_c;

    // Case equality so a floating or unknown supply pin counts as unpowered.
    assign supply_ok = (P14 === 1'b1) && (P7 === 1'b0);

    // Plain & already gives 0 on any 0, 1 on all 1s, X otherwise.
    assign gate_a = P1 & P2 & P13;
    assign gate_b = P3 & P4 & P5;
    assign gate_c = P9 & P10 & P11;

`ifdef SN7411_REG_OUT_EN
    logic q_a;
    logic q_b;
    logic q_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_a <= 1'b0;
            q_b <= 1'b0;
            q_c <= 1'b0;
        end else if (supply_ok) begin
            q_a <= gate_a;
            q_b <= gate_b;
            q_c <= gate_c;
        end else begin
            q_a <= 1'b0;
            q_b <= 1'b0;
            q_c <= 1'b0;
        end
    end

    // rst also gates the outputs so assertion shows up in the same timestep.
    always_comb begin
        P12 = 1'b0;
        P6  = 1'b0;
        P8  = 1'b0;
        if (!rst) begin
            P12 = q_a;
            P6  = q_b;
            P8  = q_c;
        end
    end
`else
    logic unused_clk;
    assign unused_clk = clk;

    always_comb begin
        P12 = 1'b0;
        P6  = 1'b0;
        P8  = 1'b0;
        if (!rst && supply_ok) begin
            P12 = gate_a;
            P6  = gate_b;
            P8  = gate_c;
        end
    end
`endif

endmodule

// File: tb/tb_sn7411_tri_and3.sv
// Self-checking bench for sn7411_tri_and3; follows SN7411_REG_OUT_EN to pick
// combinational or registered timing.
module tb_sn7411_tri_and3;

    logic P1, P2, P3, P4, P5, P7, P9, P10, P11, P13, P14;
    logic P6, P8, P12;
    logic clk, rst;

    int tests_run = 0;
    int tests_failed = 0;

    sn7411_tri_and3 dut (
        .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6), .P7(P7),
        .P8(P8), .P9(P9), .P10(P10), .P11(P11), .P12(P12), .P13(P13), .P14(P14),
        .clk(clk), .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] c;
        logic       p14;
        logic       p7;
        logic       r;
        logic [2:0] exp;   // {P12, P6, P8}
    } vec_t;

    vec_t vecs[$];

    function automatic logic and3_ref(input logic x, input logic y, input logic z);
        if (x === 1'b0 || y === 1'b0 || z === 1'b0) return 1'b0;
        if (x === 1'b1 && y === 1'b1 && z === 1'b1) return 1'b1;
        return 1'bx;
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got {P12,P6,P8}=%b, required %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                         input logic p14, input logic p7, input logic r);
        {P1, P2, P13} = a;
        {P3, P4, P5}  = b;
        {P9, P10, P11} = c;
        P14 = p14;
        P7  = p7;
        rst = r;
    endtask

    // Waits for the outputs to reflect the current inputs.
    task automatic settle();
`ifdef SN7411_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        drive(3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("reset_state", {P12, P6, P8}, 3'b000);

        for (int i = 0; i < 8; i++)
            vecs.push_back('{a: 3'(i), b: 3'b000, c: 3'b000, p14: 1'b1, p7: 1'b0, r: 1'b0,
                             exp: (i == 7) ? 3'b100 : 3'b000});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{a: 3'b000, b: 3'(i), c: 3'b000, p14: 1'b1, p7: 1'b0, r: 1'b0,
                             exp: (i == 7) ? 3'b010 : 3'b000});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{a: 3'b000, b: 3'b000, c: 3'(i), p14: 1'b1, p7: 1'b0, r: 1'b0,
                             exp: (i == 7) ? 3'b001 : 3'b000});
        vecs.push_back('{3'b111, 3'b110, 3'b111, 1'b1, 1'b0, 1'b0, 3'b101});
        vecs.push_back('{3'b111, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 3'b111});
        vecs.push_back('{3'b111, 3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000});
        vecs.push_back('{3'b111, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 3'b111});
        vecs.push_back('{3'b111, 3'b111, 3'b111, 1'b1, 1'b1, 1'b0, 3'b000});
        vecs.push_back('{3'b111, 3'b111, 3'b111, 1'b1, 1'b0, 1'b1, 3'b000});
        vecs.push_back('{3'b111, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 3'b111});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].p14, vecs[i].p7, vecs[i].r);
            settle();
            check($sformatf("vec%0d", i), {P12, P6, P8}, vecs[i].exp);
        end

        // Unknown inputs: expectation follows the four-state AND rules.
        drive(3'b011, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        P1 = 1'bx;
        settle();
        check("x_prop", {P12, P6, P8}, {and3_ref(P1, P2, P13), 2'b00});
        P2 = 1'b0;
        settle();
        check("x_with_zero", {P12, P6, P8}, 3'b000);

        // Mid-cycle reset assertion clears outputs without a clock edge.
        drive(3'b111, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0);
        settle();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", {P12, P6, P8}, 3'b000);
        #1;
        rst = 1'b0;
`ifdef SN7411_REG_OUT_EN
        #1;
        check("rst_release_wait", {P12, P6, P8}, 3'b000);
`endif
        settle();
        check("rst_release", {P12, P6, P8}, 3'b111);

`ifdef SN7411_REG_OUT_EN
        drive(3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        settle();
        check("reg_clear", {P12, P6, P8}, 3'b000);
        {P1, P2, P13} = 3'b111;
        #2;
        check("reg_before_edge", {P12, P6, P8}, 3'b000);
        @(posedge clk);
        #1;
        check("reg_after_edge", {P12, P6, P8}, 3'b100);
        #2;
        rst = 1'b1;
        #1;
        check("reg_rst_mid", {P12, P6, P8}, 3'b000);
        rst = 1'b0;
        {P1, P2, P13} = 3'b000;
        settle();
        check("reg_no_stale", {P12, P6, P8}, 3'b000);
`endif

        for (int n = 0; n < 300; n++) begin
            logic [2:0] a, b, c, exp;
            logic p14, p7, r;
            a   = 3'($urandom_range(0, 7));
            b   = 3'($urandom_range(0, 7));
            c   = 3'($urandom_range(0, 7));
            p14 = ($urandom_range(0, 9) != 0);
            p7  = ($urandom_range(0, 9) == 0);
            r   = ($urandom_range(0, 9) == 0);
            if (r || !(p14 == 1'b1 && p7 == 1'b0))
                exp = 3'b000;
            else
                exp = {a == 3'd7, b == 3'd7, c == 3'd7};
            drive(a, b, c, p14, p7, r);
            settle();
            check($sformatf("rand%0d", n), {P12, P6, P8}, exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
